// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
// Multi-cycle MULT/MULTU/DIV/DIVU engine that owns the HI/LO registers.
// A multiply uses 32 shift-add iterations. A divide uses 32 restoring
// iterations. A single FIX cycle then applies sign correction and commits
// HI/LO. The CPU is held through Stall until the result is committed.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   Start, Op[1:0]     launch (00 MULTU, 01 MULT, 10 DIVU, 11 DIV), IDLE only
//   SrcA, SrcB         multiplicand/dividend, multiplier/divisor
//   HiWrite, LoWrite   MTHI/MTLO (HI/LO <= SrcA), IDLE with Start=0 only
//   HI, LO             result registers
//   Busy, Done         registered busy level, one-cycle commit pulse
//   Stall              Busy | (Start & IDLE), combinational
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for Start; MTHI/MTLO writes honoured here
// RUN   | 32 iterations, one per clock; counter counts 0..31
// FIX   | sign correction / divide-by-zero override, commit HI/LO
module muldiv_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [1:0]  Op,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        HiWrite,
  input  logic        LoWrite,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        Done,
  output logic        Stall
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  state_t      state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic [31:0] raw_a_q, raw_a_d;
  logic        dz_q, dz_d;
  logic [63:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  // Op[0] marks the signed variants, Op[1] marks divide.
  logic [31:0] abs_a, abs_b;
  assign abs_a = (Op[0] && SrcA[31]) ? (~SrcA + 32'd1) : SrcA;
  assign abs_b = (Op[0] && SrcB[31]) ? (~SrcB + 32'd1) : SrcB;

  // Multiply step. The upper half accumulates the partial product and the
  // whole register shifts right, so finished low bits drain into [31:0].
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  assign mul_sum  = {1'b0, acc_q[63:32]} + (b_q[cnt_q] ? {1'b0, a_q} : 33'd0);
  assign mul_next = {mul_sum, acc_q[31:1]};

  // Restoring divide step. The remainder is in [63:32] and the quotient in
  // [31:0]. Because rem < divisor holds on every step, the new remainder
  // fits in 32 bits, and a 32-bit modulo subtract gives its exact value.
  logic [32:0] rem_shift;
  logic        rem_ge;
  logic [31:0] rem_sub;
  logic [63:0] div_next;
  assign rem_shift = {acc_q[63:32], a_q[5'd31 - cnt_q]};
  assign rem_ge    = (rem_shift >= {1'b0, b_q});
  assign rem_sub   = rem_shift[31:0] - b_q;
  assign div_next  = {(rem_ge ? rem_sub : rem_shift[31:0]), acc_q[30:0], rem_ge};

  logic [63:0] acc_neg;
  logic [31:0] rem_neg;
  assign acc_neg = ~acc_q + 64'd1;
  assign rem_neg = ~acc_q[63:32] + 32'd1;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    raw_a_d = raw_a_q;
    dz_d    = dz_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          op_d    = Op;
          a_d     = abs_a;
          b_d     = abs_b;
          sa_d    = Op[0] & SrcA[31];
          sb_d    = Op[0] & SrcB[31];
          raw_a_d = SrcA;
          dz_d    = Op[1] & (SrcB == 32'd0);
          acc_d   = 64'd0;
          cnt_d   = 5'd0;
          state_d = S_RUN;
        end else begin
          if (HiWrite) hi_d = SrcA;
          if (LoWrite) lo_d = SrcA;
        end
      end
      S_RUN: begin
        acc_d = op_q[1] ? div_next : mul_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        if (!op_q[1]) begin
          {hi_d, lo_d} = (op_q[0] && (sa_q ^ sb_q)) ? acc_neg : acc_q;
        end else if (dz_q) begin
          lo_d = 32'hFFFF_FFFF;
          hi_d = raw_a_q;
        end else begin
          lo_d = (op_q[0] && (sa_q ^ sb_q)) ? acc_neg[31:0] : acc_q[31:0];
          hi_d = (op_q[0] && sa_q) ? rem_neg : acc_q[63:32];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      raw_a_q <= 32'd0;
      dz_q    <= 1'b0;
      acc_q   <= 64'd0;
      cnt_q   <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      raw_a_q <= raw_a_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign HI    = hi_q;
  assign LO    = lo_q;
  assign Busy  = busy_q;
  assign Done  = done_q;
  assign Stall = busy_q | (Start & (state_q == S_IDLE));

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
  logic [1:0]  Op = 2'd0;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        HiWrite = 1'b0;
  logic        LoWrite = 1'b0;
  logic [31:0] HI, LO;
  logic        Busy, Done, Stall;

  int n_cmp = 0;
  int n_err = 0;

  muldiv_sequencer dut (
    .clk(clk), .rst_n(rst_n), .Start(Start), .Op(Op), .SrcA(SrcA), .SrcB(SrcB),
    .HiWrite(HiWrite), .LoWrite(LoWrite), .HI(HI), .LO(LO),
    .Busy(Busy), .Done(Done), .Stall(Stall)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; SrcA = a; SrcB = b;
    tick();
    Start = 1'b0;
  endtask

  // Called right after the Start edge; returns in the Done cycle.
  task automatic wait_done(output int busy_cnt, output bit seen);
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (Done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (Busy === 1'b1) busy_cnt++;
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    n_cmp++; if (HI !== 32'd0)  begin n_err++; $display("FAIL reset_hi: got %h want %h", HI, 32'd0); end
    n_cmp++; if (LO !== 32'd0)  begin n_err++; $display("FAIL reset_lo: got %h want %h", LO, 32'd0); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", Done); end
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", Stall); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_multu();
    int  bc;
    bit  seen;
    Start = 1'b1; Op = 2'b00; SrcA = 32'hFFFF_FFFF; SrcB = 32'hFFFF_FFFF;
    #1;
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL multu_start_stall: got %b want 1", Stall); end
    tick();
    Start = 1'b0;
    wait_done(bc, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL multu_done_seen: got %b want 1", seen); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL multu_busy_cycles: got %0d want 33", bc); end
    n_cmp++; if (HI !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL multu_hi: got %h want fffffffe", HI); end
    n_cmp++; if (LO !== 32'h0000_0001) begin n_err++; $display("FAIL multu_lo: got %h want 00000001", LO); end
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL multu_done_stall: got %b want 0", Stall); end
    tick();
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL multu_done_width: got %b want 0", Done); end
  endtask

  task automatic test_signed();
    logic [1:0]  ops [7] = '{2'b01, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b01};
    logic [31:0] va  [7] = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'h0000_0007, 32'h8000_0000,
                             32'd100, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] vb  [7] = '{32'd5, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                             32'd7, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] ehi [7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd0,
                             32'd2, 32'h4000_0000, 32'd0};
    logic [31:0] elo [7] = '{32'hFFFF_FFF1, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000,
                             32'd14, 32'd0, 32'h8000_0000};
    int bc;
    bit seen;
    for (int i = 0; i < 7; i++) begin
      issue(ops[i], va[i], vb[i]);
      wait_done(bc, seen);
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL signed_done[%0d]: got %b want 1", i, seen); end
      n_cmp++; if (HI !== ehi[i]) begin n_err++; $display("FAIL signed_hi[%0d]: got %h want %h", i, HI, ehi[i]); end
      n_cmp++; if (LO !== elo[i]) begin n_err++; $display("FAIL signed_lo[%0d]: got %h want %h", i, LO, elo[i]); end
      tick();
    end
  endtask

  task automatic test_div_zero();
    int bc;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      issue((i == 0) ? 2'b10 : 2'b11, 32'h1234_5678, 32'd0);
      wait_done(bc, seen);
      n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL divzero_done[%0d]: got %b want 1", i, seen); end
      n_cmp++; if (bc != 33) begin n_err++; $display("FAIL divzero_cycles[%0d]: got %0d want 33", i, bc); end
      n_cmp++; if (LO !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL divzero_lo[%0d]: got %h want ffffffff", i, LO); end
      n_cmp++; if (HI !== 32'h1234_5678) begin n_err++; $display("FAIL divzero_hi[%0d]: got %h want 12345678", i, HI); end
      tick();
    end
  endtask

  task automatic test_ignore();
    int dcnt = 0;
    int bcnt = 0;
    issue(2'b00, 32'h0001_0000, 32'h0001_0000);
    for (int k = 1; k <= 60; k++) begin
      if (k == 5) begin
        Start = 1'b1; Op = 2'b00; SrcA = 32'hFFFF_FFFF; SrcB = 32'd2;
      end else if (k == 10) begin
        Start = 1'b0; HiWrite = 1'b1; SrcA = 32'hDEAD_BEEF;
      end else begin
        Start = 1'b0; HiWrite = 1'b0;
      end
      #1;
      if (k == 5) begin
        n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL ignore_stall: got %b want 1", Stall); end
      end
      if (k == 20) begin
        n_cmp++; if (HI !== 32'h1234_5678) begin n_err++; $display("FAIL ignore_hi_hold: got %h want 12345678", HI); end
        n_cmp++; if (LO !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ignore_lo_hold: got %h want ffffffff", LO); end
      end
      if (Done === 1'b1) dcnt++;
      if (Busy === 1'b1) bcnt++;
      tick();
    end
    n_cmp++; if (dcnt != 1) begin n_err++; $display("FAIL ignore_done_count: got %0d want 1", dcnt); end
    n_cmp++; if (bcnt != 33) begin n_err++; $display("FAIL ignore_busy_cycles: got %0d want 33", bcnt); end
    n_cmp++; if (HI !== 32'd1) begin n_err++; $display("FAIL ignore_hi: got %h want 00000001", HI); end
    n_cmp++; if (LO !== 32'd0) begin n_err++; $display("FAIL ignore_lo: got %h want 00000000", LO); end
  endtask

  task automatic test_abort();
    int dcnt = 0;
    int bc;
    bit seen;
    issue(2'b11, 32'd100, 32'd7);
    for (int k = 0; k < 9; k++) tick();
    rst_n = 1'b0;
    #1;
    n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL abort_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd0) begin n_err++; $display("FAIL abort_lo: got %h want 0", LO); end
    n_cmp++; if (Busy !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", Busy); end
    n_cmp++; if (Done !== 1'b0) begin n_err++; $display("FAIL abort_done: got %b want 0", Done); end
    tick(); tick();
    rst_n = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if (Done === 1'b1) dcnt++;
      tick();
    end
    n_cmp++; if (dcnt != 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", dcnt); end
    issue(2'b00, 32'd6, 32'd7);
    wait_done(bc, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL abort_mul_done: got %b want 1", seen); end
    n_cmp++; if (LO !== 32'd42) begin n_err++; $display("FAIL abort_mul_lo: got %h want 0000002a", LO); end
    n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL abort_mul_hi: got %h want 0", HI); end
    tick();
  endtask

  task automatic test_mtlo();
    int bc;
    bit seen;
    LoWrite = 1'b1; SrcA = 32'hA5A5_A5A5;
    #1;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL mtlo_stall: got %b want 0", Stall); end
    tick();
    LoWrite = 1'b0;
    n_cmp++; if (LO !== 32'hA5A5_A5A5) begin n_err++; $display("FAIL mtlo_lo: got %h want a5a5a5a5", LO); end
    n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL mtlo_hi_kept: got %h want 0", HI); end
    HiWrite = 1'b1; LoWrite = 1'b1; SrcA = 32'h1357_9BDF;
    tick();
    HiWrite = 1'b0; LoWrite = 1'b0;
    n_cmp++; if (HI !== 32'h1357_9BDF) begin n_err++; $display("FAIL mthilo_hi: got %h want 13579bdf", HI); end
    n_cmp++; if (LO !== 32'h1357_9BDF) begin n_err++; $display("FAIL mthilo_lo: got %h want 13579bdf", LO); end
    Start = 1'b1; HiWrite = 1'b1; LoWrite = 1'b1; Op = 2'b00; SrcA = 32'd3; SrcB = 32'd4;
    tick();
    Start = 1'b0; HiWrite = 1'b0; LoWrite = 1'b0;
    n_cmp++; if (HI !== 32'h1357_9BDF) begin n_err++; $display("FAIL mthi_with_start: got %h want 13579bdf", HI); end
    wait_done(bc, seen);
    n_cmp++; if (HI !== 32'd0) begin n_err++; $display("FAIL mthi_start_hi: got %h want 0", HI); end
    n_cmp++; if (LO !== 32'd12) begin n_err++; $display("FAIL mthi_start_lo: got %h want 0000000c", LO); end
    tick();
  endtask

  task automatic test_back_to_back();
    int bc;
    bit seen;
    issue(2'b00, 32'h0000_FFFF, 32'h0000_FFFF);
    wait_done(bc, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL b2b_first_done: got %b want 1", seen); end
    n_cmp++; if (LO !== 32'hFFFE_0001) begin n_err++; $display("FAIL b2b_first_lo: got %h want fffe0001", LO); end
    Start = 1'b1; Op = 2'b00; SrcA = 32'h1234_5678; SrcB = 32'h0000_0100;
    #1;
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL b2b_stall: got %b want 1", Stall); end
    tick();
    Start = 1'b0;
    n_cmp++; if (Busy !== 1'b1) begin n_err++; $display("FAIL b2b_accepted: got %b want 1", Busy); end
    wait_done(bc, seen);
    n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL b2b_second_done: got %b want 1", seen); end
    n_cmp++; if (bc != 33) begin n_err++; $display("FAIL b2b_cycles: got %0d want 33", bc); end
    n_cmp++; if (HI !== 32'h0000_0012) begin n_err++; $display("FAIL b2b_hi: got %h want 00000012", HI); end
    n_cmp++; if (LO !== 32'h3456_7800) begin n_err++; $display("FAIL b2b_lo: got %h want 34567800", LO); end
    tick();
  endtask

  initial begin
    test_reset();
    test_multu();
    test_signed();
    test_div_zero();
    test_ignore();
    test_abort();
    test_mtlo();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
